// File: rtl/fm_radio_pkg.sv
// Shared fixed-point constants and helpers for the FM radio datapath.
package fm_radio_pkg;

  localparam int QUANT_BITS    = 10;
  localparam int QUAD1         = 804;
  localparam int QUAD3         = 2412;
  localparam int FM_DEMOD_GAIN = 758;

  // Signed divide by 2^QUANT_BITS, truncating toward zero (negative values are
  // biased up before the arithmetic shift so they round toward zero, not down).
  function automatic logic signed [63:0] dequantize(input logic signed [63:0] v);
    logic signed [63:0] bias;
    bias = v[63] ? ((64'sd1 <<< QUANT_BITS) - 64'sd1) : 64'sd0;
    return (v + bias) >>> QUANT_BITS;
  endfunction

endpackage

// File: rtl/div_signed_seq.sv
// Sequential signed restoring divider: one quotient bit per clock on the
// operand magnitudes, sign applied afterwards (quotient truncates toward zero).
module div_signed_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] rem, quo, dvs, dd_mag, dv_mag;
  logic [WIDTH:0]   trial;
  logic [CW-1:0]    count;
  logic             neg;

  always_comb begin
    dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    dv_mag = divisor[WIDTH-1] ? -divisor : divisor;
    trial  = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  end

  // quo holds the not-yet-consumed dividend bits in its top and the
  // developed quotient bits in its bottom; after WIDTH steps it is all quotient.
  assign quotient = neg ? -quo : quo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg   <= 1'b0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= '0;
        quo   <= dd_mag;
        dvs   <= dv_mag;
        neg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        count <= CW'(WIDTH);
      end else if (count != '0) begin
        if (!trial[WIDTH]) begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        count <= count - CNT_ONE;
        if (count == CNT_ONE) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fm_demod.sv
// Quadrature FM demodulator: conjugate product of consecutive I/Q samples,
// quantized arctangent through a shared sequential divider, then demod gain.
module fm_demod
  import fm_radio_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Handshake: a sample transfers on a rising edge where in_valid and in_ready
  // are both high; out_valid is a one-cycle pulse with no backpressure.

  localparam int W = DATA_WIDTH;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PROD  = 3'd1;
  localparam logic [2:0] ST_DIVS  = 3'd2;
  localparam logic [2:0] ST_DIVW  = 3'd3;
  localparam logic [2:0] ST_ANGLE = 3'd4;

  localparam logic signed [W-1:0] ONE  = W'(1);
  localparam logic signed [W-1:0] Q1   = W'(QUAD1);
  localparam logic signed [W-1:0] Q3   = W'(QUAD3);
  localparam logic signed [W-1:0] GAIN = W'(FM_DEMOD_GAIN);

  logic [2:0]          state;
  logic signed [W-1:0] i_cur, q_cur, i_prev, q_prev;
  logic signed [W-1:0] re_r, im_r, base_r;
  logic signed [W-1:0] re_n, im_n, abs_y, num, den, ratio, angle, angle_s, demod;
  logic                div_start, div_done;

  function automatic logic signed [W-1:0] deq(input logic signed [W-1:0] v);
    return W'(dequantize(64'(v)));
  endfunction

  always_comb begin
    re_n  = deq(i_prev * i_cur + q_prev * q_cur);
    im_n  = deq(i_prev * q_cur - q_prev * i_cur);
    // The +1 keeps den nonzero even when both re and im are zero.
    abs_y = (im_r[W-1] ? -im_r : im_r) + ONE;
    if (!re_r[W-1]) begin
      num = (re_r - abs_y) <<< QUANT_BITS;
      den = re_r + abs_y;
    end else begin
      num = (re_r + abs_y) <<< QUANT_BITS;
      den = abs_y - re_r;
    end
    angle   = base_r - deq(Q1 * ratio);
    angle_s = im_r[W-1] ? -angle : angle;
    demod   = deq(GAIN * angle_s);
  end

  assign in_ready  = (state == ST_IDLE);
  assign div_start = (state == ST_DIVS);

  div_signed_seq #(.WIDTH(W)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (num),
    .divisor  (den),
    .quotient (ratio),
    .done     (div_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      i_cur     <= '0;
      q_cur     <= '0;
      i_prev    <= '0;
      q_prev    <= '0;
      re_r      <= '0;
      im_r      <= '0;
      base_r    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            i_cur <= i_in;
            q_cur <= q_in;
            state <= ST_PROD;
          end
        end
        ST_PROD: begin
          re_r   <= re_n;
          im_r   <= im_n;
          i_prev <= i_cur;
          q_prev <= q_cur;
          state  <= ST_DIVS;
        end
        ST_DIVS: begin
          base_r <= re_r[W-1] ? Q3 : Q1;
          state  <= ST_DIVW;
        end
        ST_DIVW: begin
          if (div_done) state <= ST_ANGLE;
        end
        ST_ANGLE: begin
          out_data  <= demod;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
